// File: rtl/daa_readout_unpacker.sv
// Reads one NE/DAA record over four word-select phases, reassembles mantissa, exponent and
// eResult, and presents the record on a valid/ready handshake together with mant*2^exp.
module daa_readout_unpacker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  ne_bus,
  output logic [1:0]  input_sel,
  output logic        ne_freeze,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  mant,
  output logic [2:0]  exp,
  output logic [17:0] e_result,
  output logic [16:0] value,
  output logic        fmt_err,
  output logic [2:0]  dbg_state
);

  // Handshake: a record is transferred on a clock edge where out_valid and out_ready are both
  // high; out_valid stays high and the record stays stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [2:0] LAST = 3'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [9:0]  mant_q, mant_d;
  logic [2:0]  exp_q, exp_d;
  logic [17:0] e_result_q, e_result_d;
  logic [16:0] value_q, value_d;
  logic        fmt_err_q, fmt_err_d;
  logic [16:0] mant_ext;
  logic        capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      mant_q     <= '0;
      exp_q      <= '0;
      e_result_q <= '0;
      value_q    <= '0;
      fmt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      e_result_q <= e_result_d;
      value_q    <= value_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  // Words 0..2 are staged so the visible record changes only once, on the word-3 capture.
  assign mant_ext = {{7{w0_q[9]}}, w0_q};
  assign capture  = (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    e_result_d = e_result_q;
    value_d    = value_q;
    fmt_err_d  = fmt_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD0;
          cnt_d   = '0;
        end
      end
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        if (capture) begin
          cnt_d = '0;
          case (state_q)
            S_RD0:   begin w0_d = ne_bus; state_d = S_RD1; end
            S_RD1:   begin w1_d = ne_bus; state_d = S_RD2; end
            S_RD2:   begin w2_d = ne_bus; state_d = S_RD3; end
            default: begin
              mant_d     = w0_q;
              exp_d      = w1_q[2:0];
              e_result_d = {ne_bus[0], w2_q, w1_q[9:3]};
              value_d    = mant_ext << w1_q[2:0];
              fmt_err_d  = |ne_bus[9:1];
              state_d    = S_HOLD;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    input_sel = 2'd0;
    case (state_q)
      S_RD1:   input_sel = 2'd1;
      S_RD2:   input_sel = 2'd2;
      S_RD3:   input_sel = 2'd3;
      default: input_sel = 2'd0;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign ne_freeze = busy;
  assign out_valid = (state_q == S_HOLD);
  assign mant      = mant_q;
  assign exp       = exp_q;
  assign e_result  = e_result_q;
  assign value     = value_q;
  assign fmt_err   = fmt_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_daa_readout_unpacker.sv
// Bench for daa_readout_unpacker: one instance at SETTLE=1, one at SETTLE=3, checked against
// an arithmetic model of the word map.
module tb_daa_readout_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start1, out_ready1, freeze1, busy1, valid1, fe1;
  logic [9:0]  bus1, mant1;
  logic [1:0]  sel1;
  logic [2:0]  exp1, dbg1;
  logic [17:0] er1;
  logic [16:0] val1;
  logic [9:0]  words1 [4];
  assign bus1 = words1[sel1];

  logic        start3, out_ready3, freeze3, busy3, valid3, fe3;
  logic [9:0]  bus3, mant3;
  logic [1:0]  sel3;
  logic [2:0]  exp3, dbg3;
  logic [17:0] er3;
  logic [16:0] val3;
  logic [9:0]  words3 [4];
  assign bus3 = words3[sel3];

  daa_readout_unpacker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .ne_bus(bus1), .input_sel(sel1),
    .ne_freeze(freeze1), .busy(busy1), .out_valid(valid1), .out_ready(out_ready1),
    .mant(mant1), .exp(exp1), .e_result(er1), .value(val1), .fmt_err(fe1), .dbg_state(dbg1)
  );

  daa_readout_unpacker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .ne_bus(bus3), .input_sel(sel3),
    .ne_freeze(freeze3), .busy(busy3), .out_valid(valid3), .out_ready(out_ready3),
    .mant(mant3), .exp(exp3), .e_result(er3), .value(val3), .fmt_err(fe3), .dbg_state(dbg3)
  );

  int total = 0;
  int bad   = 0;
  logic [48:0] exp_q [$];

  // Record layout {mant, exp, e_result, value, fmt_err}, built with plain integer arithmetic.
  function automatic logic [48:0] model(input logic [9:0] w0, w1, w2, w3);
    int m, e, er, v;
    m  = (w0 >= 10'd512) ? int'(w0) - 1024 : int'(w0);
    e  = int'(w1) % 8;
    er = (int'(w3) % 2) * 131072 + int'(w2) * 128 + int'(w1) / 8;
    v  = m * (1 << e);
    return {w0, 3'(e), 18'(er), 17'(v), (w3 > 10'd1)};
  endfunction

  // One full read on the SETTLE=1 instance, including the handshake back to IDLE.
  task automatic run_read1(input logic [9:0] a, b, c, d, input bit ready_early, input string tag);
    int n;
    logic [48:0] e;
    words1[0] = a; words1[1] = b; words1[2] = c; words1[3] = d;
    exp_q.push_back(model(a, b, c, d));
    @(negedge clk);
    start1 = 1'b1;
    out_ready1 = ready_early;
    n = 0;
    while (!valid1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      start1 = 1'b0;
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want 5", tag, n);
    end
    e = exp_q.pop_front();
    total++;
    if ({mant1, exp1, er1, val1, fe1} !== e) begin
      bad++;
      $display("FAIL %s record: got %h, want %h", tag, {mant1, exp1, er1, val1, fe1}, e);
    end
    if (!ready_early) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      out_ready1 = 1'b1;
    end
    @(posedge clk); #1;
    total++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL %s release: valid=%b busy=%b, want 0 0", tag, valid1, busy1);
    end
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start1 = 0; out_ready1 = 0; start3 = 0; out_ready3 = 0;
    for (int i = 0; i < 4; i++) begin words1[i] = '0; words3[i] = '0; end
    #12;
    total++;
    if ({busy1, valid1, freeze1, sel1, mant1, exp1, er1, val1, fe1} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, want 0",
               {busy1, valid1, freeze1, sel1, mant1, exp1, er1, val1, fe1});
    end
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy1 !== 1'b0 || sel1 !== 2'd0 || valid1 !== 1'b0 || busy3 !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b sel=%0d valid=%b busy3=%b, want 0 0 0 0",
               busy1, sel1, valid1, busy3);
    end
  endtask

  task automatic test_basic();
    run_read1(10'h3F6, 10'h21B, 10'h14B, 10'h001, 1'b0, "basic");
    total++;
    if (mant1 !== 10'h3F6 || exp1 !== 3'd3 || er1 !== 18'h2A5C3 || val1 !== 17'h1FFB0 || fe1 !== 1'b0) begin
      bad++;
      $display("FAIL basic_const: mant=%h exp=%0d er=%h val=%h fe=%b, want 3f6 3 2a5c3 1ffb0 0",
               mant1, exp1, er1, val1, fe1);
    end
  endtask

  task automatic test_back_pressure();
    logic [48:0] e;
    int n;
    words1[0] = 10'h155; words1[1] = 10'h2AD; words1[2] = 10'h0F0; words1[3] = 10'h000;
    e = model(words1[0], words1[1], words1[2], words1[3]);
    @(negedge clk); start1 = 1'b1;
    n = 0;
    while (!valid1 && n < 100) begin @(posedge clk); #1; n++; start1 = 1'b0; end
    for (int i = 0; i < 10; i++) begin
      start1 = 1'(($urandom_range(0, 1)));
      @(posedge clk); #1;
      total++;
      if (valid1 !== 1'b1 || busy1 !== 1'b1 || {mant1, exp1, er1, val1, fe1} !== e) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b rec=%h, want 1 %h", i, valid1,
                 {mant1, exp1, er1, val1, fe1}, e);
      end
    end
    start1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: valid=%b busy=%b, want 0 0", valid1, busy1);
    end
    start1 = 1'b0; out_ready1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL bp_start_ignored: busy=%b, want 0", busy1);
    end
  endtask

  task automatic test_fmt_err();
    run_read1(10'h0AA, 10'h3C5, 10'h2FF, 10'h201, 1'b0, "fmt_set");
    total++;
    if (er1[17] !== 1'b1 || fe1 !== 1'b1) begin
      bad++;
      $display("FAIL fmt_set_bits: er17=%b fe=%b, want 1 1", er1[17], fe1);
    end
    run_read1(10'h0AA, 10'h3C5, 10'h2FF, 10'h000, 1'b1, "fmt_clr");
    total++;
    if (fe1 !== 1'b0 || er1[17] !== 1'b0) begin
      bad++;
      $display("FAIL fmt_clr_bits: er17=%b fe=%b, want 0 0", er1[17], fe1);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    bit seen;
    words1[0] = 10'h123; words1[1] = 10'h0FF; words1[2] = 10'h3A0; words1[3] = 10'h001;
    @(negedge clk); start1 = 1'b1;
    n = 0;
    while (sel1 != 2'd2 && n < 20) begin @(posedge clk); #1; n++; start1 = 1'b0; end
    @(negedge clk); rst = 1'b0;
    #1;
    total++;
    if ({busy1, valid1, sel1, mant1, exp1, er1, val1, fe1} !== '0) begin
      bad++;
      $display("FAIL abort_clear: got %h, want 0", {busy1, valid1, sel1, mant1, exp1, er1, val1, fe1});
    end
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (valid1 || busy1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_valid: activity seen=%b, want 0", seen);
    end
    run_read1(10'h201, 10'h00E, 10'h111, 10'h000, 1'b0, "abort_restart");
  endtask

  task automatic test_settle3();
    logic [48:0] e;
    words3[0] = 10'h200; words3[1] = 10'h007; words3[2] = 10'($urandom_range(0, 1023)); words3[3] = 10'h000;
    e = model(words3[0], words3[1], words3[2], words3[3]);
    @(negedge clk); start3 = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      start3 = 1'b0;
      total++;
      if (n <= 12) begin
        if (sel3 !== 2'((n - 1) / 3) || valid3 !== 1'b0) begin
          bad++;
          $display("FAIL s3_sel[%0d]: sel=%0d valid=%b, want %0d 0", n, sel3, valid3, (n - 1) / 3);
        end
      end else if (valid3 !== 1'b1) begin
        bad++;
        $display("FAIL s3_latency: valid=%b at cycle 13, want 1", valid3);
      end
    end
    total++;
    if (val3 !== 17'h10000 || {mant3, exp3, er3, val3, fe3} !== e) begin
      bad++;
      $display("FAIL s3_record: got %h, want %h", {mant3, exp3, er3, val3, fe3}, e);
    end
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (valid3 !== 1'b0 || busy3 !== 1'b0) begin
      bad++;
      $display("FAIL s3_release: valid=%b busy=%b, want 0 0", valid3, busy3);
    end
    out_ready3 = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] w3;
    for (int i = 0; i < 20; i++) begin
      w3 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 1));
      run_read1(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), w3, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_fmt_err();
    test_reset_abort();
    test_settle3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
